tt_io_bist: RTL
===============

Name: tt_io_bist

Overview:
- Parametrised on-chip self-test harness that drives a Tiny Tapeout user design's pin interface.
- Generalises the cocotb pin-level stimulus/check flow into synthesizable RTL with configurable input width, output width, vector count and settle time.
- Stimulus comes from a Galois LFSR; responses are compacted into a MISR signature and compared against a golden value.
- Sits between the top-level pins and the user core. Used for post-silicon go/no-go without an external tester.

Parameters:
- IN_W, 8, width of stimulus bus (ui_in).
- OUT_W, 16, width of captured response ({uio_out, uo_out}).
- NUM_VEC, 64, number of vectors per run; must be ≥1.
- SETTLE, 2, cycles stimulus is held before capture; must be ≥1.
- DUT_RST_CYCLES, 4, cycles dut_rst_n is held low at run start; must be ≥1.
- LFSR_SEED, 8'hA5, initial stimulus; value 0 is replaced by 1.
- LFSR_TAPS, 8'hB8, Galois taps for the stimulus LFSR, right-shifting.
- MISR_TAPS, 16'hB400, Galois taps for the signature register.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin run; sampled only in IDLE or DONE
- golden_sig  in  OUT_W  expected signature, sampled at the final capture
- dut_out  in  OUT_W  response from user core
- dut_in  out  IN_W  stimulus to user core
- dut_rst_n  out  1  active-low reset to user core
- busy  out  1  high in DUT_RST, APPLY, CAPTURE
- done  out  1  high in DONE (level)
- pass  out  1  valid when done=1
- signature  out  OUT_W  current MISR value
- vec_count  out  $clog2(NUM_VEC+1)  vectors captured this run

Behaviour:
- Reset values: state=IDLE, dut_in=0, dut_rst_n=1, busy=0, done=0, pass=0, signature=0, vec_count=0, LFSR=seed.
- Reset asserted mid-run aborts the run immediately to the reset values. No partial result is kept.
- All outputs are registered.

State machine:
- IDLE / DONE + start=1: at that edge load LFSR=seed, clear signature and vec_count, drop done and pass, set dut_rst_n=0, go to DUT_RST.
- DUT_RST: hold for DUT_RST_CYCLES cycles with dut_in=0. At exit set dut_rst_n=1, dut_in=LFSR, go to APPLY.
- APPLY: hold dut_in stable for SETTLE cycles, then go to CAPTURE.
- CAPTURE: one cycle.
  - signature <= (signature>>1) ^ (signature[0] ? MISR_TAPS : 0) ^ dut_out.
  - vec_count++.
  - LFSR advances: lfsr <= (lfsr>>1) ^ (lfsr[0] ? LFSR_TAPS : 0); dut_in <= new LFSR.
  - If vec_count reaches NUM_VEC, go to DONE and register pass = (next signature == golden_sig). Otherwise go to APPLY.
- DONE: done=1, dut_in holds its last value, dut_rst_n=1. Stays until start or rst.

Timing and boundary rules:
- start is ignored while busy=1. start held high in DONE restarts every cycle it is seen there.
- Latency: done rises DUT_RST_CYCLES + NUM_VEC*(SETTLE+1) edges after the edge that sampled start. Defaults give 196.
- NUM_VEC=1: a single capture, then DONE.
- The LFSR never reaches 0: the seed is forced nonzero and the taps are maximal.
- vec_count saturates at NUM_VEC.

Decomposition:
- Package tt_bist_pkg holds:
  - state enum (IDLE, DUT_RST, APPLY, CAPTURE, DONE);
  - default tap constants;
  - a safe_seed function.
- Sub-module tt_lfsr_galois (params W, TAPS, SEED; ports load, shift, din xor input, q). It is instantiated twice: stimulus with din=0, and MISR with din=dut_out.

Test Plan:
- Defaults, pulse start, check the first vectors → dut_rst_n low exactly 4 cycles; first dut_in=8'hA5, then 8'hEA, then 8'h75, each held for 3 cycles.
- Defaults, dut_out tied to 0, golden_sig=0 → done rises 196 edges after start; signature=0, pass=1, vec_count=64.
- NUM_VEC=1, dut_out=16'h1234, golden_sig=16'h1234 → signature=16'h1234, pass=1. Repeat with golden_sig=16'h1235 → pass=0.
- Assert rst during APPLY of vector 10 → all outputs return to reset values the same cycle. A subsequent start gives a full run identical to a fresh one.
- start pulsed repeatedly while busy → no effect, run length unchanged. start in DONE → done and pass cleared next cycle and a new run begins.
- LFSR_SEED=0 → first dut_in=8'h01, and the run completes normally.

Source files
------------

// File: rtl/tt_io_bist_pkg.sv
// Shared types and constants for the Tiny Tapeout pin-level BIST harness.
package tt_bist_pkg;

    // Run sequencer states.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DUT_RST = 3'd1,
        APPLY   = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Default stimulus seed and maximal-length Galois taps (right-shifting).
    localparam logic [7:0]  DEF_LFSR_SEED = 8'hA5;
    localparam logic [7:0]  DEF_LFSR_TAPS = 8'hB8;
    localparam logic [15:0] DEF_MISR_TAPS = 16'hB400;

    // An all-zero seed would lock the LFSR at zero, so it is replaced by 1.
    function automatic logic [63:0] safe_seed(input logic [63:0] seed);
        if (seed == 64'd0) begin
            return 64'd1;
        end else begin
            return seed;
        end
    endfunction

endpackage

// File: rtl/tt_io_bist_if.sv
// Pin-side bundle between the BIST harness and its controller / user core.
interface tt_io_bist_if #(
    parameter int unsigned IN_W    = 8,
    parameter int unsigned OUT_W   = 16,
    parameter int unsigned NUM_VEC = 64
);
    localparam int unsigned VC_W = $clog2(NUM_VEC + 1);

    logic             start;
    logic [OUT_W-1:0] golden_sig;
    logic [OUT_W-1:0] dut_out;
    logic [IN_W-1:0]  dut_in;
    logic             dut_rst_n;
    logic             busy;
    logic             done;
    logic             pass;
    logic [OUT_W-1:0] signature;
    logic [VC_W-1:0]  vec_count;

    // The harness itself.
    modport slave (
        input  start, golden_sig, dut_out,
        output dut_in, dut_rst_n, busy, done, pass, signature, vec_count
    );

    // Whoever launches runs and provides the user-core response.
    modport master (
        output start, golden_sig, dut_out,
        input  dut_in, dut_rst_n, busy, done, pass, signature, vec_count
    );
endinterface

// File: rtl/tt_lfsr_galois.sv
// Right-shifting Galois LFSR with a parallel xor input; with din tied to
// zero it is a stimulus generator, with din fed by responses it is a MISR.
module tt_lfsr_galois #(
    parameter int unsigned    W    = 8,
    parameter logic [W-1:0]   TAPS = '0,
    parameter logic [W-1:0]   SEED = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic [W-1:0] q
);
    logic [W-1:0] state;

    // Register: reload the seed, or take one Galois step folded with din.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEED;
        end else if (load) begin
            state <= SEED;
        end else if (shift) begin
            state <= (state >> 1) ^ (state[0] ? TAPS : '0) ^ din;
        end else begin
            state <= state;
        end
    end

    assign q = state;
endmodule

// File: rtl/tt_io_bist.sv
// Self-test harness: resets the user core, applies LFSR vectors, compacts
// the responses into a MISR signature and compares it with a golden value.
module tt_io_bist
    import tt_bist_pkg::*;
#(
    parameter int unsigned     IN_W           = 8,
    parameter int unsigned     OUT_W          = 16,
    parameter int unsigned     NUM_VEC        = 64,
    parameter int unsigned     SETTLE         = 2,
    parameter int unsigned     DUT_RST_CYCLES = 4,
    parameter logic [IN_W-1:0]  LFSR_SEED     = IN_W'(DEF_LFSR_SEED),
    parameter logic [IN_W-1:0]  LFSR_TAPS     = IN_W'(DEF_LFSR_TAPS),
    parameter logic [OUT_W-1:0] MISR_TAPS     = OUT_W'(DEF_MISR_TAPS)
) (
    input  logic         clk,
    input  logic         rst,
    tt_io_bist_if.slave  bus
);
    localparam int unsigned VC_W    = $clog2(NUM_VEC + 1);
    localparam int unsigned CNT_MAX = (DUT_RST_CYCLES > SETTLE) ? DUT_RST_CYCLES : SETTLE;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [IN_W-1:0] SEED_EFF = IN_W'(safe_seed(64'(LFSR_SEED)));

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [IN_W-1:0]  dut_in_q, dut_in_next;
    logic             rst_n_q, rst_n_next;
    logic             busy_q, busy_next;
    logic             done_q, done_next;
    logic             pass_q, pass_next;
    logic [VC_W-1:0]  vc_q, vc_next;
    logic             run_load;
    logic             cap_shift;
    logic [IN_W-1:0]  stim_q;
    logic [IN_W-1:0]  stim_step;
    logic [OUT_W-1:0] misr_q;
    logic [OUT_W-1:0] misr_step;

    tt_lfsr_galois #(.W(IN_W), .TAPS(LFSR_TAPS), .SEED(SEED_EFF)) u_stim (
        .clk   (clk),
        .rst   (rst),
        .load  (run_load),
        .shift (cap_shift),
        .din   ('0),
        .q     (stim_q)
    );

    tt_lfsr_galois #(.W(OUT_W), .TAPS(MISR_TAPS), .SEED('0)) u_misr (
        .clk   (clk),
        .rst   (rst),
        .load  (run_load),
        .shift (cap_shift),
        .din   (bus.dut_out),
        .q     (misr_q)
    );

    // Values the LFSR and MISR will hold after the capture edge.
    assign stim_step = (stim_q >> 1) ^ (stim_q[0] ? LFSR_TAPS : '0);
    assign misr_step = (misr_q >> 1) ^ (misr_q[0] ? MISR_TAPS : '0) ^ bus.dut_out;

    // Next-state and next-output decode for the run sequencer.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        dut_in_next = dut_in_q;
        rst_n_next  = rst_n_q;
        done_next   = done_q;
        pass_next   = pass_q;
        vc_next     = vc_q;
        run_load    = 1'b0;
        cap_shift   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_next  = DUT_RST;
                    cnt_next    = '0;
                    dut_in_next = '0;
                    rst_n_next  = 1'b0;
                    done_next   = 1'b0;
                    pass_next   = 1'b0;
                    vc_next     = '0;
                    run_load    = 1'b1;
                end else begin
                    state_next = state;
                end
            end
            DUT_RST: begin
                if (cnt == CNT_W'(DUT_RST_CYCLES - 1)) begin
                    state_next  = APPLY;
                    cnt_next    = '0;
                    rst_n_next  = 1'b1;
                    dut_in_next = stim_q;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            APPLY: begin
                if (cnt == CNT_W'(SETTLE - 1)) begin
                    state_next = CAPTURE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            CAPTURE: begin
                cap_shift   = 1'b1;
                dut_in_next = stim_step;
                if (vc_q < VC_W'(NUM_VEC)) begin
                    vc_next = vc_q + VC_W'(1);
                end else begin
                    vc_next = vc_q;
                end
                if (vc_next == VC_W'(NUM_VEC)) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                    pass_next  = (misr_step == bus.golden_sig);
                end else begin
                    state_next = APPLY;
                end
            end
            default: begin
                state_next  = IDLE;
                cnt_next    = '0;
                dut_in_next = '0;
                rst_n_next  = 1'b1;
                done_next   = 1'b0;
                pass_next   = 1'b0;
                vc_next     = '0;
            end
        endcase
        busy_next = (state_next == DUT_RST) || (state_next == APPLY) ||
                    (state_next == CAPTURE);
    end

    // State and registered outputs; reset aborts any run in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            dut_in_q <= '0;
            rst_n_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            vc_q     <= '0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            dut_in_q <= dut_in_next;
            rst_n_q  <= rst_n_next;
            busy_q   <= busy_next;
            done_q   <= done_next;
            pass_q   <= pass_next;
            vc_q     <= vc_next;
        end
    end

    assign bus.dut_in    = dut_in_q;
    assign bus.dut_rst_n = rst_n_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.signature = misr_q;
    assign bus.vec_count = vc_q;
endmodule
